// File: rtl/sram_test_pkg.sv
// Shared types, widths and the address-derived test pattern for the SRAM self-test.
// Pattern uses only the low address byte so aliased memories verify consistently.
package sram_test_pkg;
  localparam int DW = 8;
  localparam int AW = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_CHECK,
    ST_FINISH
  } test_state_t;

  typedef enum logic [1:0] {
    RQ_IDLE,
    RQ_ISSUE,
    RQ_BUSY,
    RQ_WAIT
  } req_state_t;

  function automatic logic [DW-1:0] pattern(input logic [DW-1:0] addr, input logic inv);
    return inv ? ~addr : addr;
  endfunction
endpackage

// File: rtl/sram_req_seq.sv
// Single SRAM request sequencer: one-cycle mem strobe, then waits for ready low->high.
// complete is combinational on the returning ready edge so the next request issues back-to-back.
module sram_req_seq
  import sram_test_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          start_rw,
  input  logic [AW-1:0] start_addr,
  input  logic [DW-1:0] start_dat,
  input  logic          ready,
  input  logic [DW-1:0] data2fpga,
  output logic          mem,
  output logic          rw,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data2ram,
  output logic          complete,
  output logic [DW-1:0] rdata
);

  req_state_t state;

  assign complete = (state == RQ_WAIT) && ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= RQ_IDLE;
      mem      <= 1'b0;
      rw       <= 1'b1;
      addr     <= '0;
      data2ram <= '0;
      rdata    <= '0;
    end else begin
      mem <= 1'b0;
      rw  <= 1'b1;
      case (state)
        RQ_IDLE:  state <= RQ_IDLE;
        RQ_ISSUE: state <= RQ_BUSY;
        RQ_BUSY:  if (!ready) state <= RQ_WAIT;
        RQ_WAIT: begin
          if (ready) begin
            rdata <= data2fpga;
            state <= RQ_IDLE;
          end
        end
        default:  state <= RQ_IDLE;
      endcase
      // A new request may chain directly off the completing access.
      if (start && (state == RQ_IDLE || complete)) begin
        state    <= RQ_ISSUE;
        mem      <= 1'b1;
        rw       <= start_rw;
        addr     <= start_addr;
        data2ram <= start_dat;
      end
    end
  end

endmodule

// File: rtl/sram_device_test.sv
// SRAM BIST: write pattern to 0..LAST_ADDR, read back and compare, pulse done with result.
// Optional SRAM_DEVICE_TEST_INVERT_EN adds a second sweep with the inverted pattern.
module sram_device_test
  import sram_test_pkg::*;
#(
  parameter logic [AW-1:0] LAST_ADDR = 20'hFFFFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          mem,
  output logic          rw,
  input  logic          ready,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data2ram,
  input  logic [DW-1:0] data2fpga,
  output logic          done,
  output logic          result
);

  test_state_t   state;
  logic [AW-1:0] cnt;
  logic          inv;
  logic          last;
  logic          match;
  logic          complete;
  logic [DW-1:0] rdata;

  logic          issue;
  logic          issue_rw;
  logic          issue_inv;
  logic [AW-1:0] issue_addr;
  logic [DW-1:0] issue_dat;

  assign last  = (cnt == LAST_ADDR);
  assign match = (rdata == pattern(cnt[DW-1:0], inv));

  always_comb begin
    issue      = 1'b0;
    issue_rw   = 1'b1;
    issue_inv  = inv;
    issue_addr = '0;
    case (state)
      ST_IDLE: begin
        if (en && ready) begin
          issue     = 1'b1;
          issue_rw  = 1'b0;
          issue_inv = 1'b0;
        end
      end
      ST_WRITE: begin
        if (complete) begin
          issue      = 1'b1;
          issue_rw   = last;
          issue_addr = last ? '0 : cnt + 1'b1;
        end
      end
      ST_CHECK: begin
        if (match) begin
          if (!last) begin
            issue      = 1'b1;
            issue_addr = cnt + 1'b1;
          end
`ifdef SRAM_DEVICE_TEST_INVERT_EN
          else if (!inv) begin
            issue     = 1'b1;
            issue_rw  = 1'b0;
            issue_inv = 1'b1;
          end
`endif
        end
      end
      default: issue = 1'b0;
    endcase
    issue_dat = pattern(issue_addr[DW-1:0], issue_inv);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      inv    <= 1'b0;
      done   <= 1'b0;
      result <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en && ready) begin
            cnt   <= '0;
            inv   <= 1'b0;
            state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (complete) begin
            cnt <= issue_addr;
            if (last) state <= ST_READ;
          end
        end
        ST_READ: if (complete) state <= ST_CHECK;
        ST_CHECK: begin
          // First mismatch aborts; no retry.
          if (!match) begin
            done   <= 1'b1;
            result <= 1'b0;
            state  <= ST_FINISH;
          end else if (!last) begin
            cnt   <= issue_addr;
            state <= ST_READ;
          end
`ifdef SRAM_DEVICE_TEST_INVERT_EN
          else if (!inv) begin
            cnt   <= '0;
            inv   <= 1'b1;
            state <= ST_WRITE;
          end
`endif
          else begin
            done   <= 1'b1;
            result <= 1'b1;
            state  <= ST_FINISH;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  sram_req_seq u_seq (
    .clk        (clk),
    .rst        (rst),
    .start      (issue),
    .start_rw   (issue_rw),
    .start_addr (issue_addr),
    .start_dat  (issue_dat),
    .ready      (ready),
    .data2fpga  (data2fpga),
    .mem        (mem),
    .rw         (rw),
    .addr       (addr),
    .data2ram   (data2ram),
    .complete   (complete),
    .rdata      (rdata)
  );

endmodule

// File: tb/tb_sram_device_test.sv
// Directed bench for sram_device_test against a 256-byte aliased SRAM controller model.
module tb_sram_device_test;
  localparam logic [19:0] LAST = 20'h000FF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic        mem, rw, ready, done, result;
  logic [19:0] addr;
  logic [7:0]  data2ram;
  logic [7:0]  data2fpga = 8'h00;

  int vec = 0;
  int bad = 0;

  always #10 clk = ~clk;

  sram_device_test #(.LAST_ADDR(LAST)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mem       (mem),
    .rw        (rw),
    .ready     (ready),
    .addr      (addr),
    .data2ram  (data2ram),
    .data2fpga (data2fpga),
    .done      (done),
    .result    (result)
  );

  // Controller model: ready low from tick dly+1 through dly+busy after the strobe.
  logic [7:0]  sram [256];
  int          dly   = 0;
  int          busy  = 3;
  logic        fault = 1'b0;
  logic        act   = 1'b0;
  int          tick  = 0;
  logic [19:0] q_addr = '0;
  logic        q_rw   = 1'b1;
  logic [7:0]  q_dat  = '0;

  assign ready = !(act && tick > dly);

  always @(posedge clk) begin
    if (!rst) begin
      act  <= 1'b0;
      tick <= 0;
    end else if (act) begin
      if (tick == dly + busy) begin
        act <= 1'b0;
        if (q_rw) data2fpga <= (fault && q_addr == 20'h00042) ? 8'h00 : sram[q_addr[7:0]];
        else      sram[q_addr[7:0]] <= q_dat;
      end else begin
        tick <= tick + 1;
      end
    end else if (mem) begin
      act    <= 1'b1;
      tick   <= 1;
      q_addr <= addr;
      q_rw   <= rw;
      q_dat  <= data2ram;
    end
  end

  // Bus monitor, sampled on the falling edge.
  int   cyc = 0, wr_n = 0, rd_n = 0, done_n = 0;
  int   wd_bad = 0, seq_bad = 0, viol = 0, last_mem = 0, gap = 0;
  logic prev_mem = 1'b0;
  logic saw43 = 1'b0;
  logic last_result = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (mem) begin
      if (!ready || prev_mem) viol++;
      if (!rw) begin
        if (data2ram != addr[7:0]) wd_bad++;
        if (addr != wr_n[19:0]) seq_bad++;
        wr_n++;
      end else begin
        if (addr != rd_n[19:0]) seq_bad++;
        if (addr == 20'h00043) saw43 = 1'b1;
        rd_n++;
      end
      last_mem = cyc;
    end
    if (done) begin
      done_n++;
      gap = cyc - last_mem;
      last_result = result;
    end
    prev_mem = mem;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr;
    wr_n = 0; rd_n = 0; done_n = 0; wd_bad = 0; seq_bad = 0; viol = 0;
    gap = 0; saw43 = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic start_run;
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("start_mem", mem, 1);
    chk("start_rw", rw, 0);
    chk("start_addr", addr, 0);
    #1 en = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_n == 0 && n < budget) begin
      cycles(1);
      n++;
    end
    chk("done_timeout", (done_n == 0) ? 1 : 0, 0);
    cycles(5);
    chk("done_pulses", done_n, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    // Reset and idle
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem", mem, 0);
    chk("rst_rw", rw, 1);
    chk("rst_addr", addr, 0);
    chk("rst_data2ram", data2ram, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    #1 rst = 1'b1;
    clr();
    cycles(20);
    chk("idle_reqs", wr_n + rd_n, 0);
    chk("idle_done", done_n, 0);

    // Full pass, 3-cycle controller
    clr();
    start_run();
    wait_done(4000);
    chk("pass_result", last_result, 1);
    chk("pass_writes", wr_n, 256);
    chk("pass_reads", rd_n, 256);
    chk("pass_wdata", wd_bad, 0);
    chk("pass_addr_seq", seq_bad, 0);
    chk("pass_req_rule", viol, 0);
    chk("pass_done_gap", gap, 6);
    chk("pass_result_held", result, 1);

    // Fault injected at 0x42
    fault = 1'b1;
    clr();
    start_run();
    wait_done(4000);
    chk("fault_result", last_result, 0);
    chk("fault_writes", wr_n, 256);
    chk("fault_reads", rd_n, 67);
    chk("fault_no_read43", saw43, 0);
    chk("fault_done_gap", gap, 6);
    fault = 1'b0;

    // Start pulses while busy are ignored
    clr();
    start_run();
    cycles(300);
    en = 1'b1; cycles(1); en = 1'b0;
    cycles(1500);
    en = 1'b1; cycles(3); en = 1'b0;
    wait_done(4000);
    chk("busy_en_reqs", wr_n + rd_n, 512);
    chk("busy_en_result", last_result, 1);

    // Reset during the read phase
    clr();
    start_run();
    n = 0;
    while (rd_n < 10 && n < 4000) begin
      cycles(1);
      n++;
    end
    chk("rd_phase_timeout", (rd_n < 10) ? 1 : 0, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_mem", mem, 0);
    chk("midrst_rw", rw, 1);
    chk("midrst_addr", addr, 0);
    chk("midrst_done", done, 0);
    #1 rst = 1'b1;
    clr();
    cycles(10);
    chk("midrst_idle_reqs", wr_n + rd_n, 0);
    start_run();
    wait_done(4000);
    chk("restart_result", last_result, 1);
    chk("restart_writes", wr_n, 256);
    chk("restart_addr_seq", seq_bad, 0);

    // Slow handshake: ready low one cycle late, 6 busy cycles
    dly  = 1;
    busy = 6;
    clr();
    start_run();
    wait_done(8000);
    chk("slow_result", last_result, 1);
    chk("slow_reqs", wr_n + rd_n, 512);
    chk("slow_req_rule", viol, 0);
    chk("slow_done_gap", gap, 10);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule

// File: doc/sram_device_test.md
# sram_device_test

Built-in self-test engine for the external asynchronous SRAM behind the SRAM controller. On a start pulse it writes an address-derived pattern to every location from 0 to `LAST_ADDR`, reads every location back, and compares. It then reports done with a pass/fail result. It sits between top-level test control (LEDs/UART) and the SRAM controller's mem/rw/ready request port.

## Interface
Parameters:
- `LAST_ADDR`, default 20'hFFFFF: highest address tested. The sweep is inclusive, from 0.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  synchronous, active-low reset.
- `en`  in  1  start pulse; sampled only in IDLE.
- `mem`  out  1  one-cycle request strobe to the SRAM controller.
- `rw`  out  1  request type: 1 = read, 0 = write. Valid while `mem`=1.
- `ready`  in  1  controller idle flag. It goes low the cycle after `mem` and returns high when the access is complete.
- `addr`  out  20  request address. Valid while `mem`=1 and held until the next request.
- `data2ram`  out  8  write data. Valid while `mem`=1.
- `data2fpga`  in  8  read data. Valid when `ready` returns high after a read.
- `done`  out  1  one-cycle pulse at test end.
- `result`  out  1  1 = pass, 0 = fail. Updated on the `done` cycle and held until the next start.

## Operation
- Pattern: data(a) = a[7:0]. The pattern depends only on the low address byte, so aliased or partially decoded memories still verify consistently.
- States:
  - IDLE: outputs quiet. `en`=1 and `ready`=1 → clear `addr`, go to WR_REQ. `en` in any other state is ignored.
  - WR_REQ: drive `mem`=1, `rw`=0, `data2ram`=data(`addr`) for exactly one cycle → WR_BUSY.
  - WR_BUSY: wait for `ready`=0 → WR_WAIT.
  - WR_WAIT: wait for `ready`=1.
    - If `addr`==`LAST_ADDR`: clear `addr` → RD_REQ.
    - Else: `addr`+1 → WR_REQ.
  - RD_REQ: drive `mem`=1, `rw`=1 for one cycle → RD_BUSY.
  - RD_BUSY: wait for `ready`=0 → RD_WAIT.
  - RD_WAIT: wait for `ready`=1, then capture `data2fpga` → CHECK.
  - CHECK: compare the captured data against data(`addr`).
    - Mismatch → FINISH with fail.
    - Match and `addr`==`LAST_ADDR` → FINISH with pass (or, with the macro, the next phase).
    - Otherwise `addr`+1 → RD_REQ.
  - FINISH: `done`=1 for one cycle, `result` loaded → IDLE.
- Error handling: the first mismatch aborts the test. There is no retry.
- Address counter: 20-bit, never wraps. The terminal compare uses `LAST_ADDR`.
- `rw` idles at 1 (read) outside WR_REQ so the controller never sees a stray write.

## Timing
- Reset values: `mem`=0, `rw`=1, `addr`=0, `data2ram`=0, `done`=0, `result`=0; state = IDLE.
- Reset mid-test abandons the sweep immediately. The SRAM contents are left as is.
- Start: `en` high at edge N puts `mem`=1 in cycle N+1.
- Request rule: `mem` is only ever asserted while `ready`=1, and is never high two consecutive cycles.
- Per-access cost against a controller with 3-cycle access time:
  - Write: 1 request cycle + 3 busy cycles + 1 re-issue cycle.
  - Read: adds 1 CHECK cycle.
- Total for N = `LAST_ADDR`+1 locations: about 5N + 6N + 2 cycles.
- Tolerates a controller of any latency ≥ 1 cycle, because it waits on the ready low→high edge pair.
- `done` is asserted one cycle after the final compare. `result` is valid in the same cycle as `done`.

## Configuration
- `SRAM_DEVICE_TEST_INVERT_EN`:
  - Defined: after a passing first read phase, run a second write sweep and a second read sweep with data(a) = ~a[7:0]. `result`=1 only if both read phases pass. This catches stuck-at-0/1 bits.
  - Undefined: single pattern only.

## Structure
- Shared package `sram_test_pkg`:
  - State enum.
  - Data-bus and address widths (8, 20).
  - Pattern function `pattern(addr, inv)`.
- One natural sub-module, `sram_req_seq`:
  - Issues a single request and tracks the ready low/high handshake.
  - Returns a `complete` pulse plus the captured read data.
  - The top-level FSM sequences addresses and phases.

## Test plan
- Reset then idle: `rst`=0 for 2 cycles → all outputs at reset values, `done` never pulses without `en`.
- Full pass: model a 3-cycle controller with 256-byte aliased SRAM, `LAST_ADDR`=20'h000FF, pulse `en` → 256 writes with `data2ram`==`addr`[7:0], then 256 reads, then one `done` pulse with `result`=1.
- Fault inject: model returns 8'h00 for address 20'h00042 → `done` pulses right after that read's CHECK, `result`=0, no read of 20'h00043 is issued.
- Start while busy: extra `en` pulses mid-sweep → ignored, request count stays exactly 2×(`LAST_ADDR`+1).
- Reset mid-test: `rst` low during the read phase → `mem`=0 next cycle and state IDLE. A new `en` restarts at `addr`=0 with a write.
- Handshake: controller delays `ready` low by 1 extra cycle and stretches busy to 6 cycles → still passes, and `mem` never rises while `ready`=0.
